// File: rtl/serial_minuend_recovery.sv
// Bit-serial minuend recovery: rebuilds A = D + B from LSB-first difference and subtrahend bits.
// Optional borrow-in seed (Bin_in port) is enabled by defining SERIAL_MINUEND_BORROW_IN_EN.
module serial_minuend_recovery #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Bit_valid,
  input  logic             D_in,
  input  logic             B_in,
`ifdef SERIAL_MINUEND_BORROW_IN_EN
  input  logic             Bin_in,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] A_out,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] shreg;
  logic             seed;
  logic             sum;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] shreg_next;

`ifdef SERIAL_MINUEND_BORROW_IN_EN
  assign seed = Bin_in;
`else
  assign seed = 1'b0;
`endif

  // Full-adder step: the adder's carry chain mirrors the original subtractor's borrow chain.
  assign sum        = D_in ^ B_in ^ carry;
  assign carry_next = (D_in & B_in) | (carry & (D_in ^ B_in));
  assign shreg_next = {sum, shreg[WIDTH-1:1]};
  assign last_bit   = Bit_valid && (cnt == CW'(WIDTH - 1));

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      shreg <= '0;
      A_out <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            cnt   <= '0;
            carry <= seed;
            shreg <= '0;
          end
        end
        SHIFT: begin
          if (Bit_valid) begin
            shreg <= shreg_next;
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            // Results publish on the same edge that consumes the final bit.
            if (last_bit) begin
              A_out <= shreg_next;
              Cout  <= carry_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_minuend_recovery.sv
// Self-checking bench for serial_minuend_recovery (WIDTH=4): directed cases plus randomized words
// checked against an arithmetic model A + Cout*2^W = D + B (+ borrow-in when enabled).
module tb_serial_minuend_recovery;

  localparam int W = 4;
`ifdef SERIAL_MINUEND_BORROW_IN_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  logic         Clk;
  logic         Rst;
  logic         Start;
  logic         Bit_valid;
  logic         D_in;
  logic         B_in;
`ifdef SERIAL_MINUEND_BORROW_IN_EN
  logic         Bin_in;
`endif
  logic         Busy;
  logic         Done;
  logic [W-1:0] A_out;
  logic         Cout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_a;
  logic         prev_c;

  serial_minuend_recovery #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Bit_valid (Bit_valid),
    .D_in      (D_in),
    .B_in      (B_in),
`ifdef SERIAL_MINUEND_BORROW_IN_EN
    .Bin_in    (Bin_in),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .A_out     (A_out),
    .Cout      (Cout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Streams one word starting from IDLE; optional gap before bit gap_pos, optional Start pokes.
  task automatic send_word(input string tag, input logic [W-1:0] d, input logic [W-1:0] b,
                           input logic bin, input int gap_pos, input int gap_len,
                           input logic poke_start, input logic [W-1:0] exp_a,
                           input logic exp_c);
`ifdef SERIAL_MINUEND_BORROW_IN_EN
    Bin_in = bin;
`endif
    Start = 1'b1; Bit_valid = 1'b1; D_in = 1'b1; B_in = 1'b1;
    step();
    Start = 1'b0;
    check({tag, ".busy_start"}, 32'(Busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          Bit_valid = 1'b0; D_in = $urandom_range(1); B_in = $urandom_range(1);
          Start = poke_start;
          step();
          check({tag, ".busy_gap"}, 32'(Busy), 32'd1);
          check({tag, ".done_gap"}, 32'(Done), 32'd0);
        end
        Start = 1'b0;
      end
      Bit_valid = 1'b1; D_in = d[i]; B_in = b[i];
      Start = poke_start;
      step();
      Start = 1'b0;
      if (i < W - 1) begin
        check({tag, ".done_early"}, 32'(Done), 32'd0);
        check({tag, ".a_hold"}, 32'(A_out), 32'(prev_a));
      end
    end
    Bit_valid = 1'b0;
    check({tag, ".done"}, 32'(Done), 32'd1);
    check({tag, ".busy_done"}, 32'(Busy), 32'd0);
    check({tag, ".a_out"}, 32'(A_out), 32'(exp_a));
    check({tag, ".cout"}, 32'(Cout), 32'(exp_c));
    prev_a = exp_a;
    prev_c = exp_c;
    // Start during DONE must be ignored; the block returns to IDLE.
    Start = 1'b1;
    step();
    Start = 1'b0; Bit_valid = 1'b1; D_in = 1'b1; B_in = 1'b1;
    check({tag, ".idle_done"}, 32'(Done), 32'd0);
    check({tag, ".idle_busy"}, 32'(Busy), 32'd0);
    step();
    Bit_valid = 1'b0;
    check({tag, ".idle_stay"}, 32'(Busy), 32'd0);
    check({tag, ".a_keep"}, 32'(A_out), 32'(prev_a));
  endtask

  initial begin
    logic [W:0]   total;
    logic [W-1:0] rd, rb;
    logic         rbin;
    logic [W-1:0] exp_bin_a;

    prev_a = '0; prev_c = 1'b0;
    Rst = 1'b1; Start = 1'b0; Bit_valid = 1'b0; D_in = 1'b0; B_in = 1'b0;
`ifdef SERIAL_MINUEND_BORROW_IN_EN
    Bin_in = 1'b0;
`endif
    #12;
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.a_out", 32'(A_out), 32'd0);
    check("rst.cout", 32'(Cout), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    step();

    send_word("t1", 4'b0101, 4'b0011, 1'b0, W, 0, 1'b0, 4'b1000, 1'b0);
    send_word("t2", 4'b1110, 4'b0011, 1'b0, W, 0, 1'b0, 4'b0001, 1'b1);
    send_word("t3", 4'b0110, 4'b0001, 1'b0, 2, 3, 1'b0, 4'b0111, 1'b0);
    send_word("t4", 4'b1111, 4'b1111, 1'b0, 2, 2, 1'b1, 4'b1110, 1'b1);

    // Reset after bit 2 of a word: outputs clear immediately, no Done.
    Start = 1'b1; Bit_valid = 1'b0;
    step();
    Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Bit_valid = 1'b1; D_in = 1'b1; B_in = 1'b0;
      step();
    end
    Bit_valid = 1'b0;
    Rst = 1'b1;
    #1;
    check("mid_rst.a_out", 32'(A_out), 32'd0);
    check("mid_rst.cout", 32'(Cout), 32'd0);
    check("mid_rst.busy", 32'(Busy), 32'd0);
    check("mid_rst.done", 32'(Done), 32'd0);
    step();
    Rst = 1'b0;
    prev_a = '0; prev_c = 1'b0;
    step();
    check("post_rst.done", 32'(Done), 32'd0);
    send_word("t5", 4'b0010, 4'b0010, 1'b0, W, 0, 1'b0, 4'b0100, 1'b0);

    exp_bin_a = BIN_EN ? 4'b0001 : 4'b0000;
    send_word("t6_bin", 4'b0000, 4'b0000, 1'b1, W, 0, 1'b0, exp_bin_a, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rd   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      total = {1'b0, rd} + {1'b0, rb} + ((BIN_EN && rbin) ? (W+1)'(1) : (W+1)'(0));
      send_word("rand", rd, rb, rbin, int'($urandom_range(W)), int'($urandom_range(3)),
                1'($urandom), total[W-1:0], total[W]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
